// File: rtl/dmem_arbiter_pkg.sv
// Shared widths, lane indices and the lane payload bundle for the dmem arbiter.
// Optional round-robin arbitration is enabled with `define DMEM_ARB_RR_EN.
`ifndef DATA_MEM_WIDTH
`define DATA_MEM_WIDTH 32
`endif
`ifndef DATA_MEM_DEPTH_BIT
`define DATA_MEM_DEPTH_BIT 8
`endif

package dmem_arbiter_pkg;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

    localparam int DMEM_W  = `DATA_MEM_WIDTH;
    localparam int DMEM_AW = `DATA_MEM_DEPTH_BIT;

    typedef struct packed {
        logic              ren;
        logic [DMEM_W-1:0] wen;
        logic [DMEM_AW-1:0] addr;
        logic [DMEM_W-1:0] wdata;
    } lane_t;

    // A request with neither read nor write strobe carries no work.
    function automatic logic lane_active(input logic req, input lane_t l);
        return req && (l.ren || (|l.wen));
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Two-way grant pick from active requests, last grant and saturation flags.
// Round-robin tie-break when DMEM_ARB_RR_EN is defined, else lane 0 priority.
module dmem_arb_pick
    import dmem_arbiter_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_gnt,
    input  logic i_sat0,
    input  logic i_sat1,
    output logic o_gnt0,
    output logic o_gnt1
);

    logic w_pick1;

`ifndef DMEM_ARB_RR_EN
    logic w_unused_last;
    assign w_unused_last = i_last_gnt;
`endif

    always_comb begin
        w_pick1 = 1'b0;
        if (i_req0 && i_req1) begin
            if (i_sat0) begin
                w_pick1 = 1'b0;
            end else if (i_sat1) begin
                w_pick1 = 1'b1;
            end else begin
`ifdef DMEM_ARB_RR_EN
                w_pick1 = (i_last_gnt == LANE0);
`else
                w_pick1 = 1'b0;
`endif
            end
        end else begin
            w_pick1 = i_req1;
        end
    end

    assign o_gnt0 = i_req0 && !w_pick1;
    assign o_gnt1 = i_req1 && w_pick1;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-lane data memory arbiter with starvation guard and 1-cycle read return.
// Build option: DMEM_ARB_RR_EN selects round-robin instead of lane 0 priority.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           l0_req,
    input  logic                           l0_ren,
    input  logic [`DATA_MEM_WIDTH-1:0]     l0_wen,
    input  logic [`DATA_MEM_DEPTH_BIT-1:0] l0_addr,
    input  logic [`DATA_MEM_WIDTH-1:0]     l0_wr_data,
    output logic                           l0_gnt,
    output logic                           l0_rsp_vld,
    output logic [`DATA_MEM_WIDTH-1:0]     l0_rd_data,
    input  logic                           l1_req,
    input  logic                           l1_ren,
    input  logic [`DATA_MEM_WIDTH-1:0]     l1_wen,
    input  logic [`DATA_MEM_DEPTH_BIT-1:0] l1_addr,
    input  logic [`DATA_MEM_WIDTH-1:0]     l1_wr_data,
    output logic                           l1_gnt,
    output logic                           l1_rsp_vld,
    output logic [`DATA_MEM_WIDTH-1:0]     l1_rd_data,
    output logic [`DATA_MEM_DEPTH_BIT-1:0] arb_dmem_addr,
    output logic                           arb_dmem_ren,
    output logic [`DATA_MEM_WIDTH-1:0]     arb_dmem_wen,
    output logic [`DATA_MEM_WIDTH-1:0]     arb_dmem_wr_data,
    input  logic [`DATA_MEM_WIDTH-1:0]     dmem_arb_rd_data
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] SAT = CW'(MAX_WAIT);

    logic          r_last_gnt;
    logic [CW-1:0] r_wait0;
    logic [CW-1:0] r_wait1;
    logic          r_rsp_lane;
    logic          r_rsp_pend;

    logic          w_last_gnt;
    logic [CW-1:0] w_wait0;
    logic [CW-1:0] w_wait1;
    logic          w_rsp_lane;
    logic          w_rsp_pend;

    lane_t w_lane0;
    lane_t w_lane1;
    lane_t w_sel;
    logic  w_act0;
    logic  w_act1;
    logic  w_gnt0;
    logic  w_gnt1;

    assign w_lane0 = '{ren: l0_ren, wen: l0_wen, addr: l0_addr, wdata: l0_wr_data};
    assign w_lane1 = '{ren: l1_ren, wen: l1_wen, addr: l1_addr, wdata: l1_wr_data};
    assign w_act0  = lane_active(l0_req, w_lane0);
    assign w_act1  = lane_active(l1_req, w_lane1);

    dmem_arb_pick u_pick (
        .i_req0     (w_act0),
        .i_req1     (w_act1),
        .i_last_gnt (r_last_gnt),
        .i_sat0     (r_wait0 == SAT),
        .i_sat1     (r_wait1 == SAT),
        .o_gnt0     (w_gnt0),
        .o_gnt1     (w_gnt1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt <= LANE1;
            r_wait0    <= '0;
            r_wait1    <= '0;
            r_rsp_lane <= LANE0;
            r_rsp_pend <= 1'b0;
        end else begin
            r_last_gnt <= w_last_gnt;
            r_wait0    <= w_wait0;
            r_wait1    <= w_wait1;
            r_rsp_lane <= w_rsp_lane;
            r_rsp_pend <= w_rsp_pend;
        end
    end

    always_comb begin
        w_last_gnt = r_last_gnt;
        w_wait0    = '0;
        w_wait1    = '0;
        w_rsp_lane = r_rsp_lane;
        w_rsp_pend = 1'b0;
        if (w_gnt0) begin
            w_last_gnt = LANE0;
        end else if (w_gnt1) begin
            w_last_gnt = LANE1;
        end
        // Denied-and-still-asking lanes age; anything else restarts at zero.
        if (w_act0 && !w_gnt0) begin
            w_wait0 = (r_wait0 == SAT) ? SAT : r_wait0 + CW'(1);
        end
        if (w_act1 && !w_gnt1) begin
            w_wait1 = (r_wait1 == SAT) ? SAT : r_wait1 + CW'(1);
        end
        if ((w_gnt0 && l0_ren) || (w_gnt1 && l1_ren)) begin
            w_rsp_pend = 1'b1;
            w_rsp_lane = w_gnt1 ? LANE1 : LANE0;
        end
    end

    always_comb begin
        w_sel = '0;
        if (w_gnt0) begin
            w_sel = w_lane0;
        end else if (w_gnt1) begin
            w_sel = w_lane1;
        end
        l0_gnt           = w_gnt0;
        l1_gnt           = w_gnt1;
        arb_dmem_addr    = w_sel.addr;
        arb_dmem_ren     = w_sel.ren;
        arb_dmem_wen     = w_sel.wen;
        arb_dmem_wr_data = w_sel.wdata;
        l0_rsp_vld       = r_rsp_pend && (r_rsp_lane == LANE0);
        l1_rsp_vld       = r_rsp_pend && (r_rsp_lane == LANE1);
        l0_rd_data       = l0_rsp_vld ? dmem_arb_rd_data : '0;
        l1_rd_data       = l1_rsp_vld ? dmem_arb_rd_data : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed lane traffic, behavioural memory,
// read responses checked by an independent monitor against a queue.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    typedef struct {
        logic        lane;
        logic [31:0] data;
    } rsp_t;

`ifdef DMEM_ARB_RR_EN
    localparam logic [7:0] PAT = 8'b1010_1010;
`else
    localparam logic [7:0] PAT = 8'b1000_1000;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               l0_req, l0_ren, l1_req, l1_ren;
    logic [DMEM_W-1:0]  l0_wen, l0_wr_data, l1_wen, l1_wr_data;
    logic [DMEM_AW-1:0] l0_addr, l1_addr;
    logic               l0_gnt, l0_rsp_vld, l1_gnt, l1_rsp_vld;
    logic [DMEM_W-1:0]  l0_rd_data, l1_rd_data;
    logic [DMEM_AW-1:0] arb_dmem_addr;
    logic               arb_dmem_ren;
    logic [DMEM_W-1:0]  arb_dmem_wen, arb_dmem_wr_data;
    logic [DMEM_W-1:0]  dmem_arb_rd_data = '0;

    bit [DMEM_W-1:0] mem [1 << DMEM_AW];
    bit              written [1 << DMEM_AW];

    rsp_t sb_q[$];
    int   n_pass = 0;
    int   n_tot  = 0;
    logic [7:0] pat;

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_WAIT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .l0_req(l0_req), .l0_ren(l0_ren), .l0_wen(l0_wen),
        .l0_addr(l0_addr), .l0_wr_data(l0_wr_data),
        .l0_gnt(l0_gnt), .l0_rsp_vld(l0_rsp_vld), .l0_rd_data(l0_rd_data),
        .l1_req(l1_req), .l1_ren(l1_ren), .l1_wen(l1_wen),
        .l1_addr(l1_addr), .l1_wr_data(l1_wr_data),
        .l1_gnt(l1_gnt), .l1_rsp_vld(l1_rsp_vld), .l1_rd_data(l1_rd_data),
        .arb_dmem_addr(arb_dmem_addr), .arb_dmem_ren(arb_dmem_ren),
        .arb_dmem_wen(arb_dmem_wen), .arb_dmem_wr_data(arb_dmem_wr_data),
        .dmem_arb_rd_data(dmem_arb_rd_data)
    );

    function automatic logic [31:0] init_val(input logic [DMEM_AW-1:0] a);
        return 32'hA500_0000 | 32'(a);
    endfunction

    // Memory: registered read of the pre-write line, byte-masked write.
    always @(posedge clk) begin
        if (arb_dmem_ren)
            dmem_arb_rd_data <= written[arb_dmem_addr] ?
                                mem[arb_dmem_addr] : init_val(arb_dmem_addr);
        if (|arb_dmem_wen) begin
            mem[arb_dmem_addr] <= ((written[arb_dmem_addr] ?
                                    mem[arb_dmem_addr] : init_val(arb_dmem_addr))
                                   & ~arb_dmem_wen)
                                  | (arb_dmem_wr_data & arb_dmem_wen);
            written[arb_dmem_addr] <= 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s got=%h expected=%h t=%0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    always @(negedge clk) begin
        rsp_t e;
        if (rst_n) begin
            if (l0_rsp_vld || l1_rsp_vld) begin
                if (sb_q.size() == 0) begin
                    n_tot++;
                    $display("FAIL sb_unexpected l0_vld=%b l1_vld=%b t=%0t",
                             l0_rsp_vld, l1_rsp_vld, $time);
                end else begin
                    e = sb_q.pop_front();
                    chk("rsp_l0_vld", 32'(l0_rsp_vld), 32'(e.lane == LANE0));
                    chk("rsp_l1_vld", 32'(l1_rsp_vld), 32'(e.lane == LANE1));
                    chk("rsp_data", e.lane ? l1_rd_data : l0_rd_data, e.data);
                    chk("rsp_other_zero", e.lane ? l0_rd_data : l1_rd_data, 0);
                end
            end else begin
                chk("idle_rd0_zero", l0_rd_data, 0);
                chk("idle_rd1_zero", l1_rd_data, 0);
            end
        end
    end

    task automatic idle_in();
        l0_req = 0; l0_ren = 0; l0_wen = '0; l0_addr = '0; l0_wr_data = '0;
        l1_req = 0; l1_ren = 0; l1_wen = '0; l1_addr = '0; l1_wr_data = '0;
    endtask

    task automatic push(input logic lane, input logic [31:0] d);
        rsp_t e;
        e.lane = lane;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic step(input logic e0, input logic e1, input string nm);
        @(negedge clk);
        chk({nm, "_gnt0"}, 32'(l0_gnt), 32'(e0));
        chk({nm, "_gnt1"}, 32'(l1_gnt), 32'(e1));
        if (e0 || e1) begin
            chk({nm, "_addr"}, 32'(arb_dmem_addr), 32'(e1 ? l1_addr : l0_addr));
            chk({nm, "_ren"}, 32'(arb_dmem_ren), 32'(e1 ? l1_ren : l0_ren));
            chk({nm, "_wen"}, arb_dmem_wen, e1 ? l1_wen : l0_wen);
            chk({nm, "_wdat"}, arb_dmem_wr_data, e1 ? l1_wr_data : l0_wr_data);
        end else begin
            chk({nm, "_ren"}, 32'(arb_dmem_ren), 0);
            chk({nm, "_wen"}, arb_dmem_wen, 0);
            chk({nm, "_addr"}, 32'(arb_dmem_addr), 0);
            chk({nm, "_wdat"}, arb_dmem_wr_data, 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rst_checks(input string nm);
        chk({nm, "_vld0"}, 32'(l0_rsp_vld), 0);
        chk({nm, "_vld1"}, 32'(l1_rsp_vld), 0);
        chk({nm, "_rd0"}, l0_rd_data, 0);
        chk({nm, "_rd1"}, l1_rd_data, 0);
        chk({nm, "_ren"}, 32'(arb_dmem_ren), 0);
        chk({nm, "_wen"}, arb_dmem_wen, 0);
    endtask

    task automatic do_reset();
        idle_in();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_checks("rst");
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic both_read();
        l0_req = 1; l0_ren = 1; l0_addr = 8'h20;
        l1_req = 1; l1_ren = 1; l1_addr = 8'h30;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1);
    end

    initial begin
        pat = PAT;
        idle_in();
        rst_n = 0;
        do_reset();

        // Lone lane 0 read.
        l0_req = 1; l0_ren = 1; l0_addr = 8'h10;
        push(LANE0, 32'hA500_0010);
        step(1, 0, "l0rd");
        idle_in();
        step(0, 0, "l0rd_idle");

        // Request with no strobes is ignored.
        l1_req = 1; l1_addr = 8'h44; l1_wr_data = 32'hDEAD_BEEF;
        step(0, 0, "noop");
        idle_in();

        // Contention read/write at addr 5, then read back the write.
        do_reset();
        l0_req = 1; l0_ren = 1; l0_addr = 8'h05;
        l1_req = 1; l1_wen = 32'h0000_FFFF; l1_addr = 8'h05;
        l1_wr_data = 32'h1234_ABCD;
        push(LANE0, 32'hA500_0005);
        step(1, 0, "raw_c0");
        l0_req = 0; l0_ren = 0;
        step(0, 1, "raw_c1");
        l1_req = 0; l1_wen = '0;
        l0_req = 1; l0_ren = 1;
        push(LANE0, 32'hA500_ABCD);
        step(1, 0, "raw_c2");
        idle_in();
        step(0, 0, "raw_idle");

        // Continuous contention grant pattern.
        do_reset();
        both_read();
        for (int i = 0; i < 8; i++) begin
            push(pat[i], pat[i] ? 32'hA500_0030 : 32'hA500_0020);
            step(!pat[i], pat[i], "cont");
        end
        idle_in();
        step(0, 0, "cont_idle");

        // Reset one cycle after a granted read discards its response.
        do_reset();
        both_read();
        for (int i = 0; i < 3; i++) begin
            if (i < 2)
                push(pat[i], pat[i] ? 32'hA500_0030 : 32'hA500_0020);
            step(!pat[i], pat[i], "prerst");
        end
        idle_in();
        rst_n = 0;
        #1;
        rst_checks("midrd");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        repeat (3) step(0, 0, "postrst_idle");
        both_read();
        for (int i = 0; i < 4; i++) begin
            push(pat[i], pat[i] ? 32'hA500_0030 : 32'hA500_0020);
            step(!pat[i], pat[i], "postrst");
        end
        idle_in();
        repeat (2) step(0, 0, "end_idle");

        chk("sb_empty", 32'(sb_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter: MAX_WAIT, 3, consecutive-denial limit per lane before forced grant (>=1).
REQ-002 SHALL have ports, clock and reset first; one clock; reset is asynchronous and active-low:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- lN_req  in  1  lane N access request, N=0,1
- lN_ren  in  1  lane N read
- lN_wen  in  `DATA_MEM_WIDTH  lane N byte-extended write enable
- lN_addr  in  `DATA_MEM_DEPTH_BIT  lane N line address
- lN_wr_data  in  `DATA_MEM_WIDTH  lane N write line
- lN_gnt  out  1  lane N granted this cycle
- lN_rsp_vld  out  1  lane N read data valid
- lN_rd_data  out  `DATA_MEM_WIDTH  lane N read line
- arb_dmem_addr  out  `DATA_MEM_DEPTH_BIT  memory address
- arb_dmem_ren  out  1  memory read strobe
- arb_dmem_wen  out  `DATA_MEM_WIDTH  memory byte write enable
- arb_dmem_wr_data  out  `DATA_MEM_WIDTH  memory write line
- dmem_arb_rd_data  in  `DATA_MEM_WIDTH  memory read line, valid 1 cycle after ren

Function
REQ-003 SHALL grant at most one lane per cycle; gnt combinational from req and arbitration state.
REQ-004 SHALL drive memory outputs from granted lane's inputs in the same cycle; no grant -> ren=0, wen=0, addr/wr_data=0.
REQ-005 SHALL treat request as lN_req && (lN_ren || |lN_wen); req with neither is ignored, no grant.
REQ-006 SHALL keep state: last_gnt (1 bit, lane of last grant), wait_cnt0/wait_cnt1 (clog2(MAX_WAIT+1) bits), rsp_lane (1 bit), rsp_pend (1 bit).
REQ-007 SHALL, both lanes requesting, grant the lane whose wait_cnt == MAX_WAIT; if neither saturated, apply priority per REQ-014; both saturated -> lane 0.
REQ-008 SHALL increment wait_cntN each cycle lane N requests and is denied, saturating at MAX_WAIT; clear on grant or on req low.
REQ-009 SHALL update last_gnt only on a grant cycle.
REQ-010 SHALL, on granted read, set rsp_pend=1, rsp_lane=granted lane; next cycle assert that lane's rsp_vld=1 with lN_rd_data=dmem_arb_rd_data; other lane rsp_vld=0.
REQ-011 SHALL hold lN_rd_data at 0 when its rsp_vld=0.
REQ-012 SHALL allow back-to-back grants every cycle (full throughput); read then write same address: read returns pre-write data.
REQ-013 SHALL require denied lane to hold req and payload stable; dropping req mid-wait is legal and clears its counter.

Reset
REQ-014a SHALL on rst_n low: last_gnt=1 (lane 0 wins first contention), wait counters=0, rsp_pend=0, all rsp_vld=0, rd_data=0, memory strobes 0.
REQ-014b SHALL, on reset asserted mid-read, discard pending response; no rsp_vld after reset release.

Configuration
REQ-014 SHALL with DMEM_ARB_RR_EN defined use round-robin (contention -> lane != last_gnt); without it, fixed priority lane 0, lane 1 protected only by MAX_WAIT.

Structure
REQ-015 SHALL take widths from the shared defines header (`DATA_MEM_WIDTH, `DATA_MEM_DEPTH_BIT); lane index constants LANE0/LANE1 in the shared package.
REQ-016 SHALL be single module; optional sub-module dmem_arb_pick (pure combinational 2-way pick from req, last_gnt, saturation flags).

Verification
REQ-017 Bench SHALL cover:
- reset, l0 read addr 0x10 alone -> l0_gnt=1 cycle 0, l0_rsp_vld=1 cycle 1 with memory line at 0x10.
- both lanes request every cycle, RR_EN defined -> grants alternate 0,1,0,1; each read response returns to correct lane.
- RR_EN undefined, MAX_WAIT=3, both request continuously -> l0 granted 3 cycles, l1 granted cycle 4, pattern repeats.
- l1 write wen=0xFFFF data A at addr 5 then l0 read addr 5 next cycle -> l0_rd_data=A; same-cycle contention read/write addr 5 with lane0 winning read -> old data.
- rst_n dropped cycle after granted read -> no rsp_vld after release; last_gnt=1, counters 0.
- lane req with ren=0, wen=0 -> no grant, memory strobes 0.
